// File: rtl/iob_cycle_ctl.sv
// I/O bus cycle controller: runs a 68000 async (DTACK) or 6800 sync (VPA/VMA/E)
// cycle on the IOB for each FSB request decoded into the IOB domain.
//   state | meaning
//   IDLE  | waiting for IOREQ
//   S2    | address strobe out (data strobe too on reads)
//   S4    | data strobe out on writes, timeout cleared
//   WAIT  | waiting for BERR / DTACK / VPA / timeout
//   S6    | data setup after DTACK
//   SYNC  | waiting for the VMA point of the E period
//   EHI   | VMA asserted, waiting for E to fall
//   TERM  | strobes negated, IOACK pulse
//   REC   | recovery cycle, IOBusy low
module iob_cycle_ctl #(
    parameter int E_DIV   = 10,
    parameter int E_HI    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic CLK,
    input  logic nRES,
    input  logic IOREQ,
    input  logic IACS,
    input  logic nWE,
    input  logic nDTACK,
    input  logic nVPA,
    input  logic nBERR,
    output logic nAS,
    output logic nDS,
    output logic nVMA,
    output logic E,
    output logic IOACK,
    output logic IOBERR,
    output logic IOBusy
);

    localparam int EW = $clog2(E_DIV);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [EW-1:0] E_LAST = EW'(E_DIV - 1);
    localparam logic [EW-1:0] E_RISE = EW'(E_DIV - E_HI);
    localparam logic [EW-1:0] VMA_PT = EW'(E_DIV - E_HI - 2);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        ST_IDLE, ST_S2, ST_S4, ST_WAIT, ST_S6, ST_SYNC, ST_EHI, ST_TERM, ST_REC
    } state_t;

    state_t          r_state;
    logic [EW-1:0]   r_ecnt;
    logic [EW-1:0]   w_ecnt_nxt;
    logic            r_e;
    logic [1:0]      r_dtack_s, r_vpa_s, r_berr_s;
    logic            w_dtack, w_vpa, w_berr;
    logic [TW-1:0]   r_tcnt;
    logic            r_nas, r_nds, r_nvma, r_ioack, r_ioberr, r_busy;
    logic            r_wr, r_iack;
    logic            w_to_term, w_term_err;

    // E is registered from the next count so it lines up with r_ecnt
    assign w_ecnt_nxt = (r_ecnt == E_LAST) ? '0 : r_ecnt + EW'(1);

    always_ff @(posedge CLK or negedge nRES) begin
        if (!nRES) begin
            r_ecnt <= '0;
            r_e    <= 1'b0;
        end else begin
            r_ecnt <= w_ecnt_nxt;
            r_e    <= (w_ecnt_nxt >= E_RISE);
        end
    end

    always_ff @(posedge CLK or negedge nRES) begin
        if (!nRES) begin
            r_dtack_s <= 2'b11;
            r_vpa_s   <= 2'b11;
            r_berr_s  <= 2'b11;
        end else begin
            r_dtack_s <= {r_dtack_s[0], nDTACK};
            r_vpa_s   <= {r_vpa_s[0], nVPA};
            r_berr_s  <= {r_berr_s[0], nBERR};
        end
    end

    assign w_dtack = ~r_dtack_s[1];
    assign w_vpa   = ~r_vpa_s[1];
    assign w_berr  = ~r_berr_s[1];

    // Interrupt acknowledge is autovectored: DTACK is ignored, VPA is implied
    always_comb begin
        w_to_term  = 1'b0;
        w_term_err = 1'b0;
        case (r_state)
            ST_WAIT: begin
                if (w_berr) begin
                    w_to_term  = 1'b1;
                    w_term_err = 1'b1;
                end else if (!(w_dtack && !r_iack) && !(w_vpa || r_iack)
                             && (r_tcnt == T_LAST)) begin
                    w_to_term  = 1'b1;
                    w_term_err = 1'b1;
                end
            end
            ST_S6: w_to_term = 1'b1;
            ST_SYNC: begin
                if (w_berr) begin
                    w_to_term  = 1'b1;
                    w_term_err = 1'b1;
                end
            end
            ST_EHI: begin
                if (w_berr) begin
                    w_to_term  = 1'b1;
                    w_term_err = 1'b1;
                end else if (r_ecnt == '0) begin
                    w_to_term = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge nRES) begin
        if (!nRES) begin
            r_state  <= ST_IDLE;
            r_nas    <= 1'b1;
            r_nds    <= 1'b1;
            r_nvma   <= 1'b1;
            r_ioack  <= 1'b0;
            r_ioberr <= 1'b0;
            r_busy   <= 1'b0;
            r_wr     <= 1'b0;
            r_iack   <= 1'b0;
            r_tcnt   <= '0;
        end else begin
            r_ioack  <= 1'b0;
            r_ioberr <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (IOREQ) begin
                        r_wr    <= ~nWE;
                        r_iack  <= IACS;
                        r_busy  <= 1'b1;
                        r_nas   <= 1'b0;
                        r_nds   <= ~nWE;
                        r_state <= ST_S2;
                    end
                end
                ST_S2: begin
                    if (r_wr) r_nds <= 1'b0;
                    r_state <= ST_S4;
                end
                ST_S4: begin
                    r_tcnt  <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_tcnt <= r_tcnt + TW'(1);
                    if (w_dtack && !r_iack) r_state <= ST_S6;
                    else if (w_vpa || r_iack) r_state <= ST_SYNC;
                end
                ST_SYNC: begin
                    if (w_ecnt_nxt == VMA_PT) begin
                        r_nvma  <= 1'b0;
                        r_state <= ST_EHI;
                    end
                end
                ST_S6, ST_EHI: ;
                ST_TERM: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_REC;
                end
                ST_REC:  r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
            if (w_to_term) begin
                r_state  <= ST_TERM;
                r_nas    <= 1'b1;
                r_nds    <= 1'b1;
                r_nvma   <= 1'b1;
                r_ioack  <= 1'b1;
                r_ioberr <= w_term_err;
            end
        end
    end

    assign nAS    = r_nas;
    assign nDS    = r_nds;
    assign nVMA   = r_nvma;
    assign E      = r_e;
    assign IOACK  = r_ioack;
    assign IOBERR = r_ioberr;
    assign IOBusy = r_busy;

endmodule

// File: tb/tb_iob_cycle_ctl.sv
// Scoreboard bench for iob_cycle_ctl: stimulus pushes expected IOACK cycle and
// error flag; a negedge monitor pops and checks whenever IOACK is presented.
module tb_iob_cycle_ctl;
    localparam int E_DIV   = 10;
    localparam int E_HI    = 4;
    localparam int TIMEOUT = 255;

    logic CLK = 1'b0, nRES = 1'b0, IOREQ = 1'b0, IACS = 1'b0, nWE = 1'b1;
    logic nDTACK = 1'b0, nVPA = 1'b1, nBERR = 1'b1;
    logic nAS, nDS, nVMA, E, IOACK, IOBERR, IOBusy;

    iob_cycle_ctl #(.E_DIV(E_DIV), .E_HI(E_HI), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .nRES(nRES), .IOREQ(IOREQ), .IACS(IACS), .nWE(nWE),
        .nDTACK(nDTACK), .nVPA(nVPA), .nBERR(nBERR),
        .nAS(nAS), .nDS(nDS), .nVMA(nVMA), .E(E),
        .IOACK(IOACK), .IOBERR(IOBERR), .IOBusy(IOBusy)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc++;

    int checks = 0;
    int errors = 0;
    int rel_cyc = 0;

    typedef struct {
        string name;
        int    ack_cyc;
        logic  err;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int ecount(input int c);
        return (c - rel_cyc) % E_DIV;
    endfunction

    // monitor
    logic ack_prev = 1'b0;
    always @(negedge CLK) begin
        exp_t e;
        if (ack_prev) begin
            chk("ack_one_cycle", IOACK, 0);
            chk("busy_low_in_rec", IOBusy, 0);
        end
        if (!nAS || !nDS) chk("strobe_needs_busy", IOBusy, 1);
        if (IOACK === 1'b1) begin
            chk("sb_has_entry", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk({e.name, "_ack_cycle"}, cyc, e.ack_cyc);
                chk({e.name, "_ioberr"}, IOBERR, e.err);
                chk({e.name, "_nas_term"}, nAS, 1);
                chk({e.name, "_nds_term"}, nDS, 1);
                chk({e.name, "_nvma_term"}, nVMA, 1);
                chk({e.name, "_busy_term"}, IOBusy, 1);
            end
        end
        ack_prev = IOACK;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic at_neg(input int c);
        while (cyc < c) begin
            @(posedge CLK);
            #1;
        end
        @(negedge CLK);
    endtask

    task automatic release_reset();
        repeat (2) @(posedge CLK);
        #1;
        nRES = 1'b1;
        rel_cyc = cyc;
    endtask

    task automatic wait_ack(input string name, input int max_cyc);
        logic found = 1'b0;
        for (int n = 0; n < max_cyc && !found; n++) begin
            @(negedge CLK);
            if (IOACK === 1'b1) found = 1'b1;
        end
        chk({name, "_ack_seen"}, found, 1);
        tick();
        IOREQ = 1'b0;
        IACS  = 1'b0;
        nWE   = 1'b1;
        tick();
    endtask

    task automatic request(input string name, input logic wr, input logic iacs,
                           input int lat, input logic err, output int t0);
        t0 = cyc;
        IOREQ = 1'b1;
        nWE   = ~wr;
        IACS  = iacs;
        sb.push_back('{name, t0 + lat, err});
    endtask

    initial begin
        int t0;
        logic seen;

        // reset state, DTACK held low from reset
        release_reset();
        @(negedge CLK);
        chk("rst_nas", nAS, 1);
        chk("rst_nds", nDS, 1);
        chk("rst_nvma", nVMA, 1);
        chk("rst_e", E, 0);
        chk("rst_ioack", IOACK, 0);
        chk("rst_ioberr", IOBERR, 0);
        chk("rst_busy", IOBusy, 0);
        for (int i = 0; i < E_DIV; i++) begin
            @(negedge CLK);
            chk("e_clock", E, ecount(cyc) >= E_DIV - E_HI);
        end
        tick();

        // minimum-latency read
        request("read_dtack", 1'b0, 1'b0, 5, 1'b0, t0);
        at_neg(t0);
        chk("read_nas_t0", nAS, 1);
        at_neg(t0 + 1);
        chk("read_nas_t1", nAS, 0);
        chk("read_nds_t1", nDS, 0);
        wait_ack("read_dtack", 20);

        // write, DTACK 20 cycles after nAS
        nDTACK = 1'b1;
        repeat (2) tick();
        request("write_dtack", 1'b1, 1'b0, 25, 1'b0, t0);
        at_neg(t0 + 1);
        chk("write_nas_t1", nAS, 0);
        chk("write_nds_t1", nDS, 1);
        at_neg(t0 + 2);
        chk("write_nds_t2", nDS, 0);
        while (cyc < t0 + 21) tick();
        nDTACK = 1'b0;
        wait_ack("write_dtack", 40);
        nDTACK = 1'b1;

        // VPA cycle requested at E count 7
        nVPA = 1'b0;
        repeat (2) tick();
        while (ecount(cyc) != 7) tick();
        request("vpa_sync", 1'b0, 1'b0, 14, 1'b0, t0);
        at_neg(t0 + 6);
        chk("vpa_nvma_cnt3", nVMA, 1);
        at_neg(t0 + 7);
        chk("vpa_nvma_cnt4", nVMA, 0);
        at_neg(t0 + 12);
        chk("vpa_e_cnt9", E, 1);
        at_neg(t0 + 13);
        chk("vpa_e_cnt0", E, 0);
        wait_ack("vpa_sync", 20);
        nVPA = 1'b1;

        // interrupt acknowledge, no terminator pins, requested at E count 2
        repeat (2) tick();
        while (ecount(cyc) != 2) tick();
        request("iack_auto", 1'b0, 1'b1, 19, 1'b0, t0);
        wait_ack("iack_auto", 40);

        // no response -> timeout bus error
        request("timeout", 1'b0, 1'b0, 3 + TIMEOUT, 1'b1, t0);
        wait_ack("timeout", TIMEOUT + 40);

        // BERR beats DTACK
        nBERR  = 1'b0;
        nDTACK = 1'b0;
        repeat (2) tick();
        request("berr_prio", 1'b0, 1'b0, 4, 1'b1, t0);
        wait_ack("berr_prio", 20);
        nBERR = 1'b1;

        // DTACK beats VPA
        nVPA = 1'b0;
        repeat (2) tick();
        request("dtack_vs_vpa", 1'b0, 1'b0, 5, 1'b0, t0);
        wait_ack("dtack_vs_vpa", 20);

        // reset while in EHI aborts the cycle
        nDTACK = 1'b1;
        repeat (2) tick();
        t0 = cyc;
        IOREQ = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge CLK);
            if (nVMA === 1'b0) seen = 1'b1;
        end
        chk("ehi_reached", seen, 1);
        @(posedge CLK);
        #2;
        nRES = 1'b0;
        #1;
        chk("arst_nas", nAS, 1);
        chk("arst_nds", nDS, 1);
        chk("arst_nvma", nVMA, 1);
        chk("arst_e", E, 0);
        chk("arst_busy", IOBusy, 0);
        chk("arst_ioack", IOACK, 0);
        IOREQ  = 1'b0;
        nVPA   = 1'b1;
        nDTACK = 1'b0;
        release_reset();
        repeat (2) tick();
        request("post_reset_read", 1'b0, 1'b0, 5, 1'b0, t0);
        wait_ack("post_reset_read", 20);

        repeat (3) tick();
        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit at cycle %0d", cyc);
        $fatal(1);
    end
endmodule

// File: doc/iob_cycle_ctl.md
Name: iob_cycle_ctl

Overview:
- Runs one 68000-style bus cycle on the I/O bus (IOB) for each FSB-side request that decodes into the IOB domain (SCSI, SCC, IWM, VIA, IACK, video-RAM writes).
- Produces the asynchronous (DTACK-terminated) cycle and the 6800-style synchronous (VPA/VMA/E) cycle, plus the free-running E clock.
- Returns a one-cycle completion strobe to the FSB side.
- Sits between the chip-select decode and the IOB pins: it is the responder for the IOB-domain selects and the initiator on the IOB.

Parameters:
- E_DIV, 10, E clock period in CLK cycles (low phase E_DIV-E_HI, high phase E_HI).
- E_HI, 4, E high phase length in CLK cycles.
- TIMEOUT, 255, CLK cycles waited for DTACK/VPA/BERR before forcing a bus error.

Ports:
- CLK  in  1  IOB clock; all logic on rising edge.
- nRES  in  1  asynchronous active-low reset.
- IOREQ  in  1  request: FSB address strobe active and IOB domain selected; held until IOACK.
- IACS  in  1  current request is an interrupt-acknowledge cycle.
- nWE  in  1  0 = write cycle, sampled at request acceptance.
- nDTACK  in  1  IOB async termination, active low, unsynchronised.
- nVPA  in  1  IOB sync-cycle request, active low, unsynchronised.
- nBERR  in  1  IOB bus error, active low, unsynchronised.
- nAS  out  1  IOB address strobe.
- nDS  out  1  IOB data strobe (UDS/LDS gating is done externally).
- nVMA  out  1  valid memory address for 6800 peripherals.
- E  out  1  6800 E clock.
- IOACK  out  1  one-CLK completion pulse to FSB.
- IOBERR  out  1  qualifies IOACK: cycle ended in bus error.
- IOBusy  out  1  high from acceptance until the cycle after IOACK.

Behaviour:
- Reset values: nAS=1, nDS=1, nVMA=1, E=0, IOACK=0, IOBERR=0, IOBusy=0, E counter=0, state IDLE, timeout counter=0. Reset mid-cycle aborts immediately; strobes return high asynchronously.
- E clock:
  - Counter runs 0..E_DIV-1 and wraps.
  - E=1 when count >= E_DIV-E_HI, registered.
  - Runs continuously, independent of cycles.
- Synchronisation: nDTACK, nVPA and nBERR each pass through a 2-flop synchroniser; only the synchronised versions are used.
- States:
  - IDLE: if IOREQ, latch nWE and IACS, set IOBusy, go to S2.
  - S2: nAS=0; on a read, nDS=0 in the same cycle. Go to S4.
  - S4: on a write, nDS=0 in this cycle. Clear the timeout counter and go to WAIT.
  - WAIT: increment the timeout counter. Priority is BERR > DTACK > VPA > timeout.
    - BERR → TERM with err=1.
    - DTACK → S6.
    - VPA → SYNC.
    - Counter reaching TIMEOUT → TERM with err=1.
  - S6: one wait cycle for data setup, then TERM with err=0.
  - SYNC: wait until the E counter equals E_DIV-E_HI-2, then nVMA=0 and go to EHI.
    - If the current count is already past that point, wait for the next period.
  - EHI: hold until the E falling edge (count wraps to 0), then TERM with err=0.
  - TERM: negate nAS, nDS and nVMA; IOACK=1 for exactly one CLK; IOBERR=err in the same cycle. Go to REC.
  - REC: one idle recovery cycle with IOBusy=0. Go to IDLE.
    - IOREQ still asserted here is ignored, because the FSB side drops it after IOACK.
    - A new request is accepted no earlier than the next IDLE cycle.
- Interrupt acknowledge:
  - IACS cycles are always autovectored.
  - VPA behaviour is taken regardless of the nVPA pin and does not wait for DTACK.
  - The nVMA/E sequence is still run.
- Simultaneous DTACK and VPA in WAIT: DTACK wins.
- nBERR asserted during SYNC or EHI: terminate at the next cycle with err=1 and negate nVMA.
- Strobe ordering: nAS and nDS never assert while IOBusy=0, and all three strobes negate in the same cycle.
- Minimum cycle latency, read with DTACK already asserted: request to IOACK = 6 CLK (IDLE, S2, S4, WAIT, S6, TERM).

Test Plan:
- Read, nDTACK held low from reset, IOREQ at t0: nAS/nDS fall at t0+1, IOACK pulse at t0+5, IOBERR=0, nAS high at t0+5.
- Write (nWE=0), nDTACK asserted 20 CLK after nAS: nDS falls one CLK after nAS; IOACK appears 2 synchroniser cycles plus S6 after nDTACK; no early termination.
- VPA cycle, request with E count=7: nVMA=0 when count=4 in the next period; IOACK in the cycle after E falls; nVMA high in the TERM cycle.
- IACS=1, nVPA and nDTACK held high: sync cycle completes with IOBERR=0; no timeout.
- No response (all terminators high): IOACK with IOBERR=1 exactly TIMEOUT cycles after WAIT entry.
- nRES pulsed low in EHI: all strobes high asynchronously, E=0; after release the next IOREQ is serviced normally.
